ysyx_25040111_arbiter: RTL

Two-master, one-slave AXI4-Lite-style bus arbiter between the core's instruction fetch unit (IFU, read-only) and load/store unit (LSU, read/write) and the single downstream memory port (SoC `io_master_*` or local Xbar). It grants the port to one master per transaction, holds the grant until the response handshake, and uses round-robin between simultaneous requesters so neither master starves. All transactions are single-beat (len 0, INCR burst, id 0).

---
 rtl/ysyx_25040111_arbiter_pkg.sv | 24 ++
 rtl/ysyx_25040111_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040111_arbiter_pkg.sv
// Shared types for the IFU/LSU memory-port arbiter.
// State encoding, grant constants and fixed AXI attributes.
package ysyx_25040111_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RD_IFU = 2'b01,
      RD_LSU = 2'b10,
      WR_LSU = 2'b11
   } arb_state_e;

   localparam logic GNT_IFU = 1'b0;
   localparam logic GNT_LSU = 1'b1;

   localparam int         ID_W       = 4;
   localparam logic [7:0] AXI_LEN    = 8'd0;
   localparam logic [1:0] AXI_INCR   = 2'b01;

   // A pending LSU read is always served before its write.
   function automatic arb_state_e lsu_pick(input logic arvalid);
      return arvalid ? RD_LSU : WR_LSU;
   endfunction

endpackage

// File: rtl/ysyx_25040111_arbiter.sv
// Round-robin arbiter: IFU (read) and LSU (read/write) onto one
// single-beat AXI4-Lite-style memory port.
module ysyx_25040111_arbiter
   import ysyx_25040111_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                reset,

   input  logic                ifu_arvalid,
   output logic                ifu_arready,
   input  logic [ADDR_W-1:0]   ifu_araddr,
   input  logic [2:0]          ifu_arsize,
   output logic                ifu_rvalid,
   input  logic                ifu_rready,
   output logic [DATA_W-1:0]   ifu_rdata,
   output logic [1:0]          ifu_rresp,

   input  logic                lsu_arvalid,
   output logic                lsu_arready,
   input  logic [ADDR_W-1:0]   lsu_araddr,
   input  logic [2:0]          lsu_arsize,
   output logic                lsu_rvalid,
   input  logic                lsu_rready,
   output logic [DATA_W-1:0]   lsu_rdata,
   output logic [1:0]          lsu_rresp,
   input  logic                lsu_awvalid,
   output logic                lsu_awready,
   input  logic [ADDR_W-1:0]   lsu_awaddr,
   input  logic [2:0]          lsu_awsize,
   input  logic                lsu_wvalid,
   output logic                lsu_wready,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wstrb,
   output logic                lsu_bvalid,
   input  logic                lsu_bready,
   output logic [1:0]          lsu_bresp,

   output logic                mem_arvalid,
   input  logic                mem_arready,
   output logic [ADDR_W-1:0]   mem_araddr,
   output logic [2:0]          mem_arsize,
   output logic [7:0]          mem_arlen,
   output logic [1:0]          mem_arburst,
   output logic [ID_W-1:0]     mem_arid,
   input  logic                mem_rvalid,
   output logic                mem_rready,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic [1:0]          mem_rresp,
   input  logic                mem_rlast,
   output logic                mem_awvalid,
   input  logic                mem_awready,
   output logic [ADDR_W-1:0]   mem_awaddr,
   output logic [2:0]          mem_awsize,
   output logic [7:0]          mem_awlen,
   output logic [1:0]          mem_awburst,
   output logic [ID_W-1:0]     mem_awid,
   output logic                mem_wvalid,
   input  logic                mem_wready,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   output logic                mem_wlast,
   input  logic                mem_bvalid,
   output logic                mem_bready,
   input  logic [1:0]          mem_bresp,

   output logic                busy
);

   arb_state_e state, state_n;
   logic       last_grant, last_grant_n;
   logic       busy_q;
   logic       ifu_req, lsu_req;
   logic       gnt_ifu, gnt_lsu;

   // Single-beat protocol: rlast carries no information here.
   logic       unused_rlast;
   assign unused_rlast = mem_rlast;

   assign mem_arlen   = AXI_LEN;
   assign mem_awlen   = AXI_LEN;
   assign mem_arburst = AXI_INCR;
   assign mem_awburst = AXI_INCR;
   assign mem_arid    = '0;
   assign mem_awid    = '0;
   assign mem_wlast   = mem_wvalid;
   assign busy        = busy_q & ~reset;

   assign ifu_req = ifu_arvalid;
   assign lsu_req = lsu_arvalid | lsu_awvalid;
   assign gnt_ifu = ifu_req & (~lsu_req | (last_grant == GNT_LSU));
   assign gnt_lsu = lsu_req & ~gnt_ifu;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= GNT_LSU;
         busy_q     <= 1'b0;
      end else begin
         state      <= state_n;
         last_grant <= last_grant_n;
         busy_q     <= (state_n != IDLE);
      end
   end

   always_comb begin
      state_n      = state;
      last_grant_n = last_grant;
      unique case (state)
         IDLE: begin
            unique case (1'b1)
               gnt_ifu: begin
                  state_n      = RD_IFU;
                  last_grant_n = GNT_IFU;
               end
               gnt_lsu: begin
                  state_n      = lsu_pick(lsu_arvalid);
                  last_grant_n = GNT_LSU;
               end
               default: ;
            endcase
         end
         RD_IFU, RD_LSU: begin
            if (mem_rvalid && mem_rready) state_n = IDLE;
         end
         WR_LSU: begin
            if (mem_bvalid && mem_bready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      mem_arvalid = 1'b0;
      mem_araddr  = '0;
      mem_arsize  = '0;
      mem_rready  = 1'b0;
      mem_awvalid = 1'b0;
      mem_awaddr  = '0;
      mem_awsize  = '0;
      mem_wvalid  = 1'b0;
      mem_wdata   = '0;
      mem_wstrb   = '0;
      mem_bready  = 1'b0;
      ifu_arready = 1'b0;
      ifu_rvalid  = 1'b0;
      ifu_rdata   = '0;
      ifu_rresp   = '0;
      lsu_arready = 1'b0;
      lsu_rvalid  = 1'b0;
      lsu_rdata   = '0;
      lsu_rresp   = '0;
      lsu_awready = 1'b0;
      lsu_wready  = 1'b0;
      lsu_bvalid  = 1'b0;
      lsu_bresp   = '0;
      // Outputs are held quiet while reset is asserted, even mid-transaction.
      if (!reset) begin
         unique case (state)
            RD_IFU: begin
               mem_arvalid = ifu_arvalid;
               mem_araddr  = ifu_araddr;
               mem_arsize  = ifu_arsize;
               ifu_arready = mem_arready;
               ifu_rvalid  = mem_rvalid;
               ifu_rdata   = mem_rdata;
               ifu_rresp   = mem_rresp;
               mem_rready  = ifu_rready;
            end
            RD_LSU: begin
               mem_arvalid = lsu_arvalid;
               mem_araddr  = lsu_araddr;
               mem_arsize  = lsu_arsize;
               lsu_arready = mem_arready;
               lsu_rvalid  = mem_rvalid;
               lsu_rdata   = mem_rdata;
               lsu_rresp   = mem_rresp;
               mem_rready  = lsu_rready;
            end
            WR_LSU: begin
               mem_awvalid = lsu_awvalid;
               mem_awaddr  = lsu_awaddr;
               mem_awsize  = lsu_awsize;
               lsu_awready = mem_awready;
               mem_wvalid  = lsu_wvalid;
               mem_wdata   = lsu_wdata;
               mem_wstrb   = lsu_wstrb;
               lsu_wready  = mem_wready;
               lsu_bvalid  = mem_bvalid;
               lsu_bresp   = mem_bresp;
               mem_bready  = lsu_bready;
            end
            default: ;
         endcase
      end
   end

endmodule
